pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, width of the performance counters.
REQ-002 Parameter ADDR_W, default 4, register-address width.
REQ-003 Parameter MC_CYCLES, default 4, EX occupancy of a multi-cycle instruction; legal range 2..2^WIDTH-1.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 ID_OP1_ADDR, ID_OP2_ADDR  in  ADDR_W  source registers of the instruction in ID.
REQ-008 EX_DEST_ADDR  in  ADDR_W  destination register of the instruction held in ID/EX.
REQ-009 EX_MEM_READ  in  1  instruction in ID/EX is a load.
REQ-010 EX_MULTICYCLE  in  1  instruction in ID/EX needs MC_CYCLES of EX.
REQ-011 BRANCH_TAKEN  in  1  EX resolved a taken branch this cycle.
REQ-012 MEM_STALL  in  1  memory stage not ready; freeze the front end.
REQ-013 PC_WRITE_EN, IFID_WRITE_EN, IDEX_WRITE_EN  out  1  stage-register load enables.
REQ-014 IFID_FLUSH, IDEX_FLUSH  out  1  clear the stage register to zero at the next edge; dominant over write enable.
REQ-015 IDEX_READ_EN  out  1  ID/EX output enable.
REQ-016 STATE  out  2  current FSM state: BOOT=0, RUN=1, MC_BUSY=2.
REQ-017 STALL_COUNT, FLUSH_COUNT  out  WIDTH  performance counters.

Function
REQ-018 FSM: BOOT -> RUN unconditionally after one cycle; RUN -> MC_BUSY per REQ-022; MC_BUSY -> RUN when the counter is 0 and MEM_STALL=0.
REQ-019 BOOT: all write enables 0, both flushes 1, IDEX_READ_EN 0.
REQ-020 RUN and MC_BUSY: IDEX_READ_EN 1.
REQ-021 RUN, priority highest first:
  - MEM_STALL=1: all write enables 0, flushes 0.
  - BRANCH_TAKEN=1: all write enables 1, IFID_FLUSH=1, IDEX_FLUSH=1.
  - EX_MULTICYCLE=1: see REQ-022.
  - Load-use hazard: PC/IFID enables 0, IDEX_WRITE_EN=1, IDEX_FLUSH=1 (bubble).
  - Otherwise: all enables 1, flushes 0.
REQ-022 Multi-cycle entry from RUN: all write enables 0 this cycle; 16-bit counter loaded with MC_CYCLES-2; next state MC_BUSY.
REQ-023 Load-use hazard = EX_MEM_READ and EX_DEST_ADDR != 0 and EX_DEST_ADDR equals ID_OP1_ADDR or ID_OP2_ADDR; combinational, same cycle, no state change.
REQ-024 MC_BUSY:
  - Counter > 0: all write enables 0, flushes 0; counter decrements.
  - Counter == 0: all enables 1, flushes 0 (release cycle).
  - Result: the instruction occupies EX for exactly MC_CYCLES cycles.
  - BRANCH_TAKEN, EX_MULTICYCLE and load-use are ignored.
REQ-025 MEM_STALL in MC_BUSY: all write enables 0; counter and state hold.
REQ-026 MEM_STALL in BOOT: no effect.
REQ-027 Write enables and flushes are combinational from state, counter and inputs; STATE is registered.

Reset
REQ-028 RST=1 forces BOOT, counter 0 and performance counters 0 immediately, independent of CLK.
REQ-029 While RST=1, outputs take their BOOT values (REQ-019).
REQ-030 Reset mid-MC_BUSY abandons the operation; the first edge after release executes BOOT.

Configuration
REQ-031 Macro HAZ_PERF_CNT_EN defined:
  - STALL_COUNT increments on each RUN/MC_BUSY cycle with PC_WRITE_EN=0.
  - FLUSH_COUNT increments on each cycle with IFID_FLUSH=1 outside BOOT.
  - Both saturate at all-ones.
REQ-032 Macro HAZ_PERF_CNT_EN undefined: both ports are present, tied to zero, and no counter flops are built.

Structure
REQ-033 Shared package holds the state encoding constants (BOOT, RUN, MC_BUSY) and the hazard-reason enumeration.
REQ-034 One sub-module, haz_detect: pure combinational load-use comparator (REQ-023).

Verification
REQ-035 Reset release -> one BOOT cycle (flushes 1, enables 0), then RUN with all enables 1 and STATE=1.
REQ-036 EX_MEM_READ=1, EX_DEST_ADDR=3, ID_OP2_ADDR=3 -> PC_WRITE_EN=0, IFID_WRITE_EN=0, IDEX_FLUSH=1 for exactly that cycle; EX_DEST_ADDR=0 -> no stall.
REQ-037 EX_MULTICYCLE=1 with MC_CYCLES=4 -> enables 0 for 3 cycles, 1 on the 4th; STATE sequence 1,2,2,2,1.
REQ-038 BRANCH_TAKEN=1 together with a load-use hazard -> both flushes 1, PC_WRITE_EN=1, no stall.
REQ-039 MEM_STALL=1 for 2 cycles in the middle of MC_BUSY -> MC_BUSY lengthens by 2 cycles and the counter holds.
REQ-040 HAZ_PERF_CNT_EN defined, 5 stall cycles -> STALL_COUNT=5; RST asserted mid-MC_BUSY -> STATE=0 and counters 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// hazard-reason enumeration and the reason-to-stage-control decode.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned STATE_W  = 2;
  localparam int unsigned REASON_W = 3;
  localparam int unsigned MC_CNT_MIN_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MC_BUSY = 2'd2
  } state_e;

  // Why the front end is doing what it is doing this cycle.
  typedef enum logic [REASON_W-1:0] {
    HZ_NONE       = 3'd0,
    HZ_BOOT       = 3'd1,
    HZ_MEM_STALL  = 3'd2,
    HZ_BRANCH     = 3'd3,
    HZ_MULTICYCLE = 3'd4,
    HZ_LOAD_USE   = 3'd5
  } haz_reason_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctrl_t;

  // Stall reasons (memory, multi-cycle) fall through to the all-zero default.
  function automatic stage_ctrl_t reason_ctrl(haz_reason_e r);
    stage_ctrl_t c;
    c = '0;
    case (r)
      HZ_NONE: begin
        c.pc_we   = 1'b1;
        c.ifid_we = 1'b1;
        c.idex_we = 1'b1;
      end
      HZ_BOOT: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      HZ_BRANCH: begin
        c.pc_we      = 1'b1;
        c.ifid_we    = 1'b1;
        c.idex_we    = 1'b1;
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      HZ_LOAD_USE: begin
        c.idex_we    = 1'b1;
        c.idex_flush = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_haz_detect.sv
// Load-use hazard comparator: the load in ID/EX writes a register that the
// instruction in ID reads. Register 0 is never a hazard.
module haz_detect #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_dest_addr_i,
  input  logic [ADDR_W-1:0] id_op1_addr_i,
  input  logic [ADDR_W-1:0] id_op2_addr_i,
  output logic              load_use_o
);

  logic dest_nonzero;
  logic op_match;

  assign dest_nonzero = (ex_dest_addr_i != '0);
  assign op_match     = (ex_dest_addr_i == id_op1_addr_i) ||
                        (ex_dest_addr_i == id_op2_addr_i);
  assign load_use_o   = ex_mem_read_i && dest_nonzero && op_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles and flushes for load-use,
// multi-cycle EX, taken branches and memory stalls.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ID_OP1_ADDR,
  input  logic [ADDR_W-1:0] ID_OP2_ADDR,
  input  logic [ADDR_W-1:0] EX_DEST_ADDR,
  input  logic              EX_MEM_READ,
  input  logic              EX_MULTICYCLE,
  input  logic              BRANCH_TAKEN,
  input  logic              MEM_STALL,
  output logic              PC_WRITE_EN,
  output logic              IFID_WRITE_EN,
  output logic              IDEX_WRITE_EN,
  output logic              IFID_FLUSH,
  output logic              IDEX_FLUSH,
  output logic              IDEX_READ_EN,
  output logic [1:0]        STATE,
  output logic [WIDTH-1:0]  STALL_COUNT,
  output logic [WIDTH-1:0]  FLUSH_COUNT
);

  // Wide enough for the 16-bit occupancy counter and any legal MC_CYCLES.
  localparam int unsigned MC_CNT_W = (WIDTH > MC_CNT_MIN_W) ? WIDTH : MC_CNT_MIN_W;
  localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_CYCLES - 2);

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  haz_reason_e         reason;
  stage_ctrl_t         ctrl;
  logic                load_use;
  logic                active;

  haz_detect #(
    .ADDR_W (ADDR_W)
  ) u_haz_detect (
    .ex_mem_read_i  (EX_MEM_READ),
    .ex_dest_addr_i (EX_DEST_ADDR),
    .id_op1_addr_i  (ID_OP1_ADDR),
    .id_op2_addr_i  (ID_OP2_ADDR),
    .load_use_o     (load_use)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_BOOT;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Next state, occupancy counter and the reason driving the stage controls.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    reason   = HZ_BOOT;
    case (state_q)
      ST_BOOT: begin
        reason  = HZ_BOOT;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (MEM_STALL) begin
          reason = HZ_MEM_STALL;
        end else if (BRANCH_TAKEN) begin
          reason = HZ_BRANCH;
        end else if (EX_MULTICYCLE) begin
          reason   = HZ_MULTICYCLE;
          mc_cnt_d = MC_LOAD;
          state_d  = ST_MC_BUSY;
        end else if (load_use) begin
          reason = HZ_LOAD_USE;
        end else begin
          reason = HZ_NONE;
        end
      end
      ST_MC_BUSY: begin
        if (MEM_STALL) begin
          reason = HZ_MEM_STALL;
        end else if (mc_cnt_q != '0) begin
          reason   = HZ_MULTICYCLE;
          mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
        end else begin
          reason  = HZ_NONE;
          state_d = ST_RUN;
        end
      end
      default: begin
        reason   = HZ_BOOT;
        state_d  = ST_BOOT;
        mc_cnt_d = '0;
      end
    endcase
  end

  assign ctrl   = reason_ctrl(reason);
  assign active = (state_q == ST_RUN) || (state_q == ST_MC_BUSY);

  assign PC_WRITE_EN   = ctrl.pc_we;
  assign IFID_WRITE_EN = ctrl.ifid_we;
  assign IDEX_WRITE_EN = ctrl.idex_we;
  assign IFID_FLUSH    = ctrl.ifid_flush;
  assign IDEX_FLUSH    = ctrl.idex_flush;
  assign IDEX_READ_EN  = active;
  assign STATE         = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; BOOT cycles are never counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && !ctrl.pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + WIDTH'(1);
    end
    if (active && ctrl.ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_COUNT = stall_cnt_q;
  assign FLUSH_COUNT = flush_cnt_q;
`else
  assign STALL_COUNT = '0;
  assign FLUSH_COUNT = '0;
`endif

endmodule
